// File: rtl/conv_pkg.sv
`default_nettype none
// conv_pkg: shared sample/result types and converter offsets for conv_arbiter. Rev 1.0
package conv_pkg;
  localparam int SAMPLE_W   = 4;
  localparam int RESULT_W   = 5;
  localparam int POS_OFFSET = 3;
  localparam int NEG_OFFSET = 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [RESULT_W-1:0] result_t;
endpackage
`default_nettype wire

// File: rtl/conv_core.sv
`default_nettype none
// conv_core: combinational converter, y = x+3 for x >= 0, y = x-2 for x < 0. Rev 1.0
module conv_core
  import conv_pkg::*;
(
  input  sample_t sample,
  output result_t result
);
  result_t ext;

  // Range is -10..+10, so 5 bits never overflow and no saturation is needed.
  assign ext    = {sample[SAMPLE_W-1], sample};
  assign result = sample[SAMPLE_W-1] ? ext - result_t'(NEG_OFFSET)
                                     : ext + result_t'(POS_OFFSET);
endmodule
`default_nettype wire

// File: rtl/conv_arbiter.sv
`default_nettype none
// conv_arbiter: two requesters share one converter feeding an output FIFO (FIFO_DEPTH 2 or 4).
// Define CONV_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority. Rev 1.0
module conv_arbiter
  import conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    req0_valid,
  input  sample_t req0_data,
  output logic    req0_ready,
  input  logic    req1_valid,
  input  sample_t req1_data,
  output logic    req1_ready,
  output logic    out_valid,
  output result_t out_data,
  output logic    out_id,
  input  logic    out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  result_t         mem_data [FIFO_DEPTH];
  logic            mem_id   [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            last_grant;
  logic            unused_last_grant;

  logic            pop;
  logic            push;
  logic            can_push;
  logic            prefer0;
  logic            grant0;
  logic            grant1;
  sample_t         mux_sample;
  result_t         conv_result;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Outputs are forced low while rst is high, so nothing leaks out in the reset cycle.
  assign out_valid = !rst && (count != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_id    = out_valid ? mem_id[rd_ptr] : 1'b0;
  assign pop       = out_valid && out_ready;
  assign can_push  = !rst && ((count < CW'(FIFO_DEPTH)) || pop);

`ifdef CONV_ARB_RR_EN
  assign prefer0 = last_grant;
`else
  assign prefer0 = 1'b1;
`endif
  assign unused_last_grant = last_grant;

  assign grant0     = can_push && req0_valid && (!req1_valid || prefer0);
  assign grant1     = can_push && req1_valid && (!req0_valid || !prefer0);
  assign push       = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mux_sample = grant1 ? req1_data : req0_data;

  conv_core u_core (
    .sample (mux_sample),
    .result (conv_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= conv_result;
        mem_id[wr_ptr]   <= grant1;
        wr_ptr           <= ptr_next(wr_ptr);
        last_grant       <= grant1;
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_conv_arbiter.sv
`default_nettype none
// tb_conv_arbiter: directed and random stimulus against a queue-based reference model. Rev 1.0
module tb_conv_arbiter;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0;
  logic signed [3:0] req0_data = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic signed [3:0] req1_data = '0;
  logic              req1_ready;
  logic              out_valid;
  logic signed [4:0] out_data;
  logic              out_id;
  logic              out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int id;
    int data;
  } beat_t;
  beat_t m_q[$];
  int    m_last = 1;

  conv_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int conv(input int x);
    return (x >= 0) ? x + 3 : x - 2;
  endfunction

  // One clock: drive inputs, compare against the model, then advance the model at the edge.
  task automatic step(input bit r, input bit v0, input int d0, input bit v1, input int d1,
                      input bit ordy);
    int win;
    bit exp_ov;
    bit room;
    @(negedge clk);
    rst        = r;
    req0_valid = v0;
    req0_data  = d0[3:0];
    req1_valid = v1;
    req1_data  = d1[3:0];
    out_ready  = ordy;
    #1;
    exp_ov = !r && (m_q.size() > 0);
    check("out_valid", int'(out_valid), int'(exp_ov));
    if (exp_ov) begin
      check("out_data", int'(out_data), m_q[0].data);
      check("out_id", int'(out_id), m_q[0].id);
    end else if (r) begin
      check("rst_out_data", int'(out_data), 0);
      check("rst_out_id", int'(out_id), 0);
    end
    room = !r && (m_q.size() < DEPTH || (m_q.size() == DEPTH && ordy));
    win  = -1;
    if (room) begin
      if (v0 && v1) begin
`ifdef CONV_ARB_RR_EN
        win = (m_last == 0) ? 1 : 0;
`else
        win = 0;
`endif
      end else if (v0) begin
        win = 0;
      end else if (v1) begin
        win = 1;
      end
    end
    check("req0_ready", int'(req0_ready), int'(win == 0));
    check("req1_ready", int'(req1_ready), int'(win == 1));
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_last = 1;
    end else begin
      if (exp_ov && ordy) void'(m_q.pop_front());
      if (win >= 0) begin
        m_q.push_back('{win, conv(win == 0 ? d0 : d1)});
        m_last = win;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 3, 1, -3, 1);

    for (int x = -8; x <= 7; x++) step(0, 1, x, 0, 0, 1);
    drain();

    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 1, 5, 1, -4, 1);
    drain();

    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, -1, 0, 0, 0);
    step(0, 1, 2, 1, 2, 0);
    step(0, 0, 0, 1, 7, 1);
    drain();

    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, -5, 0);
    step(1, 1, 4, 1, 4, 1);
    step(0, 1, 6, 1, -7, 1);
    step(0, 1, 6, 1, -7, 1);
    drain();

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), int'($urandom_range(0, 15)) - 8,
           1'($urandom), int'($urandom_range(0, 15)) - 8, ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_arbiter.md
CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: output FIFO entries, SHALL be 2 or 4.
REQ-002 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1: reset, synchronous, active-high.
REQ-004 req0_valid  input  1: requester 0 has a sample.
REQ-005 req0_data  input  4: requester 0 sample, signed two's complement.
REQ-006 req0_ready  output  1: requester 0 sample accepted this cycle when high together with req0_valid.
REQ-007 req1_valid  input  1: requester 1 has a sample.
REQ-008 req1_data  input  4: requester 1 sample, signed.
REQ-009 req1_ready  output  1: requester 1 sample accepted this cycle when high together with req1_valid.
REQ-010 out_valid  output  1: FIFO head is valid.
REQ-011 out_data  output  5: converted result, signed.
REQ-012 out_id  output  1: source requester of out_data.
REQ-013 out_ready  input  1: consumer takes the head when high together with out_valid.

Function
REQ-014 The block SHALL share one combinational converter between both requesters, computing y = x+3 when x >= 0 and y = x-2 when x < 0, sign-extended to 5 bits.
REQ-015 Result range SHALL be -10..+10; no overflow is possible and no saturation logic is present.
REQ-016 At most one requester SHALL be granted per cycle.
REQ-017 A grant SHALL be issued only if req_valid is high and the FIFO can accept: count < FIFO_DEPTH, or count == FIFO_DEPTH with out_valid and out_ready both high.
REQ-018 reqN_ready SHALL be high only for the granted requester, and never without that requester's valid.
REQ-019 The push-side readiness path from out_ready to reqN_ready is combinational and is permitted.
REQ-020 Conversion latency SHALL be 1 cycle: a sample accepted at edge k SHALL appear at out_data at edge k+1 when the FIFO was empty.
REQ-021 The FIFO SHALL preserve acceptance order; out_id SHALL carry the granted index.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, at any count including full.
REQ-023 A pop on empty SHALL be ignored and out_valid SHALL stay low.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Arbitration SHALL use a 1-bit last_grant register, updated only on an accepted transfer.
REQ-026 When only one requester is valid, that requester SHALL win; when both are valid, the arbitration policy of REQ-031/REQ-032 SHALL apply.
REQ-027 Inputs SHALL be sampled only on acceptance; req_data may change freely while not accepted.

Reset
REQ-028 With rst high at an edge: FIFO count = 0, pointers = 0, last_grant = 1 (so requester 0 wins the first contention).
REQ-029 With rst high: out_valid = 0, out_data = 0, out_id = 0, req0_ready = req1_ready = 0.
REQ-030 Reset asserted mid-stream SHALL discard all FIFO contents, with no output beat in the reset cycle or the cycle after.

Configuration
REQ-031 Macro CONV_ARB_RR_EN defined: round-robin; on contention the requester != last_grant SHALL win.
REQ-032 Macro CONV_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention; last_grant is still kept but unused for decisions.

Structure
REQ-033 A shared package conv_pkg SHALL hold the sample_t (4-bit signed) and result_t (5-bit signed) typedefs and the constants POS_OFFSET = 3 and NEG_OFFSET = 2.
REQ-034 The converter SHALL be a sub-module conv_core (purely combinational, sample_t in, result_t out), instantiated once.
REQ-035 Arbitration, FIFO and handshake logic SHALL reside in conv_arbiter.

Verification
REQ-036 Exhaustive sweep: req0 only, x = -8..7, out_ready = 1 -> out_data = -10, -9, ..., -3, then 3, 4, ..., 10; out_id = 0; one beat per cycle.
REQ-037 Contention with CONV_ARB_RR_EN: both valid continuously, req0 = 5, req1 = -4, out_ready = 1 -> grants alternate 0, 1, 0, 1; out_data sequence 8, -6, 8, -6.
REQ-038 Contention without the macro: same stimulus as REQ-037 -> req1_ready never asserts; every beat is out_id = 0, out_data = 8.
REQ-039 Backpressure: FIFO_DEPTH = 2, out_ready = 0, push 0 then -1 -> both ready signals low on the third cycle; then raise out_ready with req1 = 7 valid -> pop 3 and push 10 in the same cycle; beats 3, -3, 10 in order.
REQ-040 Reset mid-stream: FIFO holds 2 entries, assert rst for 1 cycle -> out_valid = 0 for 2 cycles and the next beat comes from a fresh push with requester 0 winning contention.
